dev_tx_cmd_sc_fifo: RTL



---
 rtl/dev_tx_cmd_sc_fifo_if.sv | 29 ++
 rtl/dev_tx_cmd_sc_fifo.sv | 104 ++++++++++
 2 files changed

// File: rtl/dev_tx_cmd_sc_fifo_if.sv
// Command FIFO port bundle: push side, pop side, occupancy and sticky error flags.
// Handshake: a push happens on any cycle with wr_en=1 and full_n=1; a pop happens on any
// cycle with rd_en=1 and empty_n=1; rd_data is the head word whenever empty_n=1.
interface dev_tx_cmd_sc_fifo_if #(
  parameter int P_FIFO_DATA_WIDTH  = 30,
  parameter int P_FIFO_DEPTH_WIDTH = 5
);
  logic                          wr_en;
  logic [P_FIFO_DATA_WIDTH-1:0]  wr_data;
  logic                          full_n;
  logic                          afull_n;
  logic                          rd_en;
  logic [P_FIFO_DATA_WIDTH-1:0]  rd_data;
  logic                          empty_n;
  logic [P_FIFO_DEPTH_WIDTH:0]   fill_cnt;
  logic                          err_clr;
  logic                          ovf_err;
  logic                          udf_err;

  modport master (
    output wr_en, wr_data, rd_en, err_clr,
    input  full_n, afull_n, rd_data, empty_n, fill_cnt, ovf_err, udf_err
  );

  modport slave (
    input  wr_en, wr_data, rd_en, err_clr,
    output full_n, afull_n, rd_data, empty_n, fill_cnt, ovf_err, udf_err
  );
endinterface

// File: rtl/dev_tx_cmd_sc_fifo.sv
// Single-clock FWFT command FIFO with occupancy, almost-full and sticky error flags.
// Define DEV_TX_CMD_SC_FIFO_FWD_EN to compile in the write-to-head forward path.
module dev_tx_cmd_sc_fifo #(
  parameter int P_FIFO_DATA_WIDTH  = 30,
  parameter int P_FIFO_DEPTH_WIDTH = 5,
  parameter int P_AFULL_MARGIN     = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  dev_tx_cmd_sc_fifo_if.slave  fifo
);

  localparam int DEPTH = 2 ** P_FIFO_DEPTH_WIDTH;

  typedef logic [P_FIFO_DEPTH_WIDTH:0]  ptr_t;
  typedef logic [P_FIFO_DATA_WIDTH-1:0] word_t;

  localparam ptr_t DEPTH_C  = ptr_t'(DEPTH);
  localparam ptr_t AFULL_TH = ptr_t'(DEPTH - P_AFULL_MARGIN);

  word_t mem [DEPTH];

  ptr_t  rear_q, rear_d;
  ptr_t  front_q, front_d;
  ptr_t  commit_q, commit_d;
  ptr_t  fill_q, fill_d;
  ptr_t  rd_addr;
  word_t rd_data_q, rd_data_d;
  logic  ovf_q, ovf_d;
  logic  udf_q, udf_d;
  logic  full_n, afull_n, empty_n;
  logic  wr_ok, rd_ok, fwd;

  always_comb begin
    full_n  = (fill_q != DEPTH_C);
    afull_n = (fill_q < AFULL_TH);
    // commit_q trails rear_q so a head is only advertised once the RAM can return it
    empty_n = (commit_q != front_q);
    wr_ok   = fifo.wr_en & full_n;
    rd_ok   = fifo.rd_en & empty_n;
    rd_addr = rd_ok ? (front_q + ptr_t'(1)) : front_q;
    rear_d  = wr_ok ? (rear_q + ptr_t'(1)) : rear_q;
    front_d = rd_addr;

`ifdef DEV_TX_CMD_SC_FIFO_FWD_EN
    // The incoming word lands exactly where the next head will be read from, with nothing older pending
    fwd = wr_ok && (rear_q == rd_addr) && (commit_q == rd_addr);
`else
    fwd = 1'b0;
`endif

    commit_d  = fwd ? rear_d : rear_q;
    rd_data_d = fwd ? fifo.wr_data : mem[rd_addr[P_FIFO_DEPTH_WIDTH-1:0]];

    case ({wr_ok, rd_ok})
      2'b10:   fill_d = fill_q + ptr_t'(1);
      2'b01:   fill_d = fill_q - ptr_t'(1);
      default: fill_d = fill_q;
    endcase

    ovf_d = ovf_q;
    udf_d = udf_q;
    if (fifo.err_clr) begin
      ovf_d = 1'b0;
      udf_d = 1'b0;
    end else begin
      if (fifo.wr_en && !full_n)  ovf_d = 1'b1;
      if (fifo.rd_en && !empty_n) udf_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem[rear_q[P_FIFO_DEPTH_WIDTH-1:0]] <= fifo.wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rear_q    <= '0;
      front_q   <= '0;
      commit_q  <= '0;
      fill_q    <= '0;
      rd_data_q <= '0;
      ovf_q     <= 1'b0;
      udf_q     <= 1'b0;
    end else begin
      rear_q    <= rear_d;
      front_q   <= front_d;
      commit_q  <= commit_d;
      fill_q    <= fill_d;
      rd_data_q <= rd_data_d;
      ovf_q     <= ovf_d;
      udf_q     <= udf_d;
    end
  end

  assign fifo.full_n   = full_n;
  assign fifo.afull_n  = afull_n;
  assign fifo.empty_n  = empty_n;
  assign fifo.rd_data  = rd_data_q;
  assign fifo.fill_cnt = fill_q;
  assign fifo.ovf_err  = ovf_q;
  assign fifo.udf_err  = udf_q;

endmodule
